load_store_unit: RTL and testbench

//  Memory-access stage directly upstream of DataMemory: accepts byte/half/word/dword

---
 rtl/load_store_unit.sv | 201 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage in front of a doubleword-only DataMemory.
// Accepts byte/half/word/dword loads and stores over valid/ready. Loads are
// lane-extracted and zero- or sign-extended. Sub-doubleword stores are done as
// read-modify-write because the memory only writes whole doublewords.
module load_store_unit #(
    parameter int MEM_READ_LATENCY = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [63:0] ReqAddress,
    input  logic [63:0] ReqWriteData,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [63:0] RespData,
    output logic        RespError,
    output logic [63:0] Address,
    output logic [63:0] WriteData,
    output logic        MemoryRead,
    output logic        MemoryWrite,
    input  logic [63:0] ReadData
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    // RD lasts MEM_READ_LATENCY+1 cycles; the counter runs 0..LAST_RD.
    localparam logic [2:0] LAST_RD = 3'(MEM_READ_LATENCY);

    state_t      r_state;
    state_t      w_next_state;

    // Request copy taken at the handshake; nothing downstream looks at Req* again.
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic [63:0] r_resp_data;
    logic        r_resp_err;
    logic [2:0]  r_rd_cnt;

    logic        w_req_fire;
    logic        w_misaligned;
    logic        w_rd_last;
    logic [5:0]  w_shift;
    logic [63:0] w_mask;
    logic [63:0] w_shifted;
    logic [63:0] w_lane;
    logic        w_sign;
    logic [63:0] w_load_data;
    logic [63:0] w_merged;

    assign w_req_fire = (r_state == S_IDLE) && ReqValid;
    assign w_rd_last  = (r_state == S_RD) && (r_rd_cnt == LAST_RD);

    // Natural alignment of the incoming request: the low log2(size) address bits must be zero.
    always_comb begin
        case (ReqSize)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = ReqAddress[0];
            2'd2:    w_misaligned = |ReqAddress[1:0];
            default: w_misaligned = |ReqAddress[2:0];
        endcase
    end

    // Lane geometry of the latched request: byte offset within the doubleword and width mask.
    assign w_shift = {r_addr[2:0], 3'b000};

    // Width mask and sign bit of the addressed lane; the sign comes from the unmasked shifted data.
    always_comb begin
        w_mask = '1;
        w_sign = w_shifted[63];
        case (r_size)
            2'd0: begin
                w_mask = 64'h0000_0000_0000_00FF;
                w_sign = w_shifted[7];
            end
            2'd1: begin
                w_mask = 64'h0000_0000_0000_FFFF;
                w_sign = w_shifted[15];
            end
            2'd2: begin
                w_mask = 64'h0000_0000_FFFF_FFFF;
                w_sign = w_shifted[31];
            end
            default: begin
                w_mask = '1;
                w_sign = w_shifted[63];
            end
        endcase
    end

    // Load path works on ReadData directly, since it is captured on the last RD edge.
    assign w_shifted   = ReadData >> w_shift;
    assign w_lane      = w_shifted & w_mask;
    assign w_load_data = (r_signed && w_sign) ? (w_lane | ~w_mask) : w_lane;

    // Store path: replace only the addressed lane(s) of the fetched doubleword.
    // For a dword store the mask covers everything, so r_rdata drops out.
    assign w_merged = (r_rdata & ~(w_mask << w_shift)) | ((r_wdata & w_mask) << w_shift);

    // State register; Reset from any state returns to IDLE and abandons the operation.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic for the request/read/write/response sequence.
    // NOTE: the default is assigned before the case so no path leaves w_next_state unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (ReqValid) begin
                    if (w_misaligned) begin
                        w_next_state = S_RESP;
                    end else if (ReqWrite && (ReqSize == 2'd3)) begin
                        w_next_state = S_WR;
                    end else begin
                        w_next_state = S_RD;
                    end
                end
            end
            S_RD: begin
                if (r_rd_cnt == LAST_RD) begin
                    w_next_state = r_write ? S_WR : S_RESP;
                end
            end
            S_WR: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                if (RespReady) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Request capture, read-latency counter, read-data capture and response registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_write     <= 1'b0;
            r_size      <= 2'd0;
            r_signed    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
            r_rd_cnt    <= '0;
        end else begin
            if (w_req_fire) begin
                r_write     <= ReqWrite;
                r_size      <= ReqSize;
                r_signed    <= ReqSigned;
                r_addr      <= ReqAddress;
                r_wdata     <= ReqWriteData;
                r_resp_err  <= w_misaligned;
                r_resp_data <= '0;
                r_rd_cnt    <= '0;
            end
            if (r_state == S_RD) begin
                r_rd_cnt <= r_rd_cnt + 3'd1;
                if (w_rd_last) begin
                    r_rdata <= ReadData;
                    if (!r_write) begin
                        r_resp_data <= w_load_data;
                    end
                end
            end
        end
    end

    assign ReqReady    = (r_state == S_IDLE);
    assign RespValid   = (r_state == S_RESP);
    assign RespData    = r_resp_data;
    assign RespError   = r_resp_err;
    assign Address     = {r_addr[63:3], 3'b000};
    assign MemoryRead  = (r_state == S_RD);
    assign MemoryWrite = (r_state == S_WR);
    assign WriteData   = (r_state == S_WR) ? w_merged : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a latency-modelled doubleword memory, a byte-level
// reference model, directed scenarios followed by randomized traffic.
module tb_load_store_unit;

    localparam int L = 1;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [63:0] ReqAddress;
    logic [63:0] ReqWriteData;
    logic        RespValid;
    logic        RespReady;
    logic [63:0] RespData;
    logic        RespError;
    logic [63:0] Address;
    logic [63:0] WriteData;
    logic        MemoryRead;
    logic        MemoryWrite;
    logic [63:0] ReadData;

    int vectors     = 0;
    int miscompares = 0;

    load_store_unit #(.MEM_READ_LATENCY(L)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .ReqValid     (ReqValid),
        .ReqReady     (ReqReady),
        .ReqWrite     (ReqWrite),
        .ReqSize      (ReqSize),
        .ReqSigned    (ReqSigned),
        .ReqAddress   (ReqAddress),
        .ReqWriteData (ReqWriteData),
        .RespValid    (RespValid),
        .RespReady    (RespReady),
        .RespData     (RespData),
        .RespError    (RespError),
        .Address      (Address),
        .WriteData    (WriteData),
        .MemoryRead   (MemoryRead),
        .MemoryWrite  (MemoryWrite),
        .ReadData     (ReadData)
    );

    always #5 Clock = ~Clock;

    // Physical memory: 32 doublewords, read data appears L cycles after a read cycle.
    logic [63:0] phys_mem [32];
    logic [63:0] rd_pipe  [L];
    assign ReadData = rd_pipe[L-1];

    function automatic logic [63:0] init_word(input int i);
        return (64'h9E37_79B9_7F4A_7C15 * 64'(i + 1)) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) phys_mem[i] <= init_word(i);
        for (int i = 0; i < L; i++) rd_pipe[i] <= '0;
        forever begin
            @(posedge Clock);
            for (int i = L - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
            rd_pipe[0] <= MemoryRead ? phys_mem[Address[7:3]] : {$urandom, $urandom};
            if (MemoryWrite) phys_mem[Address[7:3]] <= WriteData;
        end
    end

    // Reference model: the same memory viewed as 256 little-endian bytes.
    logic [7:0] ref_bytes [256];

    function automatic logic [63:0] model_dword(input int d);
        logic [63:0] v;
        v = '0;
        for (int b = 7; b >= 0; b--) v = (v << 8) | 64'(ref_bytes[d*8 + b]);
        return v;
    endfunction

    function automatic logic [63:0] model_load(input int a, input int n, input logic sgn);
        logic [63:0] v;
        logic [7:0]  top;
        v = '0;
        for (int b = n - 1; b >= 0; b--) v = (v << 8) | 64'(ref_bytes[a + b]);
        top = ref_bytes[a + n - 1];
        if (sgn && (n < 8) && top[7]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    task automatic model_store(input int a, input int n, input logic [63:0] wd);
        for (int b = 0; b < n; b++) ref_bytes[a + b] = wd[8*b +: 8];
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // One full request/response transaction; starts and ends just after a falling edge.
    task automatic do_req(input string name, input logic wr, input logic [1:0] size,
                          input logic sgn, input logic [63:0] addr, input logic [63:0] wd,
                          input int hold, output logic [63:0] got);
        int          n, idx, c, nrd, nwr, nboth, exp_lat, exp_rd, exp_wr;
        logic        aligned, seen, exp_err;
        logic [63:0] exp_data, exp_wdata, line;
        n        = 1 << size;
        idx      = int'(addr[7:0]);
        aligned  = (idx % n) == 0;
        line     = {addr[63:3], 3'b000};
        exp_data = '0;
        exp_wdata = '0;
        exp_err  = !aligned;
        if (!aligned) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (wr) begin
            model_store(idx, n, wd);
            exp_wdata = model_dword(idx / 8);
            exp_rd  = (n == 8) ? 0 : L + 1;
            exp_wr  = 1;
            exp_lat = (n == 8) ? 2 : 3 + L;
        end else begin
            exp_data = model_load(idx, n, sgn);
            exp_rd = L + 1; exp_wr = 0; exp_lat = 2 + L;
        end

        ReqValid = 1'b1; ReqWrite = wr; ReqSize = size; ReqSigned = sgn;
        ReqAddress = addr; ReqWriteData = wd;
        check({name, ".req_ready"}, 64'(ReqReady), 64'd1);
        @(posedge Clock);
        @(negedge Clock);
        // Scramble the request inputs: only the latched copy may matter now.
        ReqValid = 1'b0; ReqWrite = 1'($urandom); ReqSize = 2'($urandom);
        ReqSigned = 1'($urandom); ReqAddress = {$urandom, $urandom};
        ReqWriteData = {$urandom, $urandom};

        c = 1; nrd = 0; nwr = 0; nboth = 0; seen = 1'b0;
        while (!seen && c <= 20) begin
            if (MemoryRead && MemoryWrite) nboth++;
            if (MemoryRead) begin
                nrd++;
                check({name, ".rd_addr"}, Address, line);
            end
            if (MemoryWrite) begin
                nwr++;
                check({name, ".wr_addr"}, Address, line);
                check({name, ".wr_data"}, WriteData, exp_wdata);
            end
            if (RespValid) begin
                seen = 1'b1;
            end else begin
                @(posedge Clock);
                @(negedge Clock);
                c++;
            end
        end
        check({name, ".resp_seen"}, 64'(seen), 64'd1);
        if (!seen) begin
            Reset = 1'b1;
            @(posedge Clock);
            @(negedge Clock);
            Reset = 1'b0;
            got = '0;
            return;
        end
        check({name, ".latency"}, 64'(c), 64'(exp_lat));
        check({name, ".read_cycles"}, 64'(nrd), 64'(exp_rd));
        check({name, ".write_cycles"}, 64'(nwr), 64'(exp_wr));
        check({name, ".strobe_overlap"}, 64'(nboth), 64'd0);
        check({name, ".resp_error"}, 64'(RespError), 64'(exp_err));
        check({name, ".resp_data"}, RespData, exp_data);
        check({name, ".busy"}, 64'(ReqReady), 64'd0);
        got = RespData;

        for (int h = 0; h < hold; h++) begin
            @(posedge Clock);
            @(negedge Clock);
            check({name, ".hold_valid"}, 64'(RespValid), 64'd1);
            check({name, ".hold_data"}, RespData, exp_data);
            check({name, ".hold_error"}, 64'(RespError), 64'(exp_err));
            check({name, ".hold_busy"}, 64'(ReqReady), 64'd0);
            check({name, ".hold_strobes"}, 64'({MemoryRead, MemoryWrite}), 64'd0);
        end

        RespReady = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        RespReady = 1'b0;
        check({name, ".idle_ready"}, 64'(ReqReady), 64'd1);
        check({name, ".idle_valid"}, 64'(RespValid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got;
        logic [63:0] w;
        logic [1:0]  size;
        logic [63:0] addr;

        for (int i = 0; i < 32; i++) begin
            w = init_word(i);
            for (int b = 0; b < 8; b++) ref_bytes[i*8 + b] = w[8*b +: 8];
        end

        Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'd0; ReqSigned = 1'b0;
        ReqAddress = '0; ReqWriteData = '0; RespReady = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;

        // Reset state
        check("rst.req_ready", 64'(ReqReady), 64'd1);
        check("rst.resp_valid", 64'(RespValid), 64'd0);
        check("rst.resp_error", 64'(RespError), 64'd0);
        check("rst.mem_read", 64'(MemoryRead), 64'd0);
        check("rst.mem_write", 64'(MemoryWrite), 64'd0);
        check("rst.resp_data", RespData, 64'd0);
        check("rst.address", Address, 64'd0);
        check("rst.write_data", WriteData, 64'd0);

        // Dword store, then signed/unsigned byte loads of its top byte
        do_req("t1_sd", 1'b1, 2'd3, 1'b0, 64'h8, 64'h8877_6655_4433_2211, 0, got);
        do_req("t2_lb", 1'b0, 2'd0, 1'b1, 64'hF, 64'd0, 0, got);
        check("t2.signed_const", got, 64'hFFFF_FFFF_FFFF_FF88);
        do_req("t2_lbu", 1'b0, 2'd0, 1'b0, 64'hF, 64'd0, 0, got);
        check("t2.unsigned_const", got, 64'h88);

        // Half store via read-modify-write, then word load over it
        do_req("t3_sh", 1'b1, 2'd1, 1'b0, 64'hA, 64'h0000_0000_0000_BEEF, 0, got);
        check("t3.mem_const", phys_mem[1], 64'h8877_6655_BEEF_2211);
        do_req("t3_lwu", 1'b0, 2'd2, 1'b0, 64'h8, 64'd0, 0, got);
        check("t3.load_const", got, 64'hBEEF_2211);

        // Misaligned word load
        do_req("t4_mis", 1'b0, 2'd2, 1'b0, 64'h6, 64'd0, 0, got);

        // Back-pressured response, then an immediate follow-up request
        do_req("t5_hold", 1'b0, 2'd2, 1'b1, 64'hC, 64'd0, 3, got);
        do_req("t5_next", 1'b0, 2'd3, 1'b0, 64'h8, 64'd0, 0, got);

        // Reset in the middle of a byte store's read phase
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd0; ReqSigned = 1'b0;
        ReqAddress = 64'h10; ReqWriteData = 64'hA5;
        check("t6.req_ready", 64'(ReqReady), 64'd1);
        @(posedge Clock);
        @(negedge Clock);
        ReqValid = 1'b0;
        check("t6.in_rd", 64'(MemoryRead), 64'd1);
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t6.no_write", 64'(MemoryWrite), 64'd0);
            check("t6.no_resp", 64'(RespValid), 64'd0);
            check("t6.ready", 64'(ReqReady), 64'd1);
            @(posedge Clock);
            @(negedge Clock);
        end
        check("t6.mem_0x10", phys_mem[2], model_dword(2));

        // Randomized traffic, mostly aligned
        for (int t = 0; t < 150; t++) begin
            size = 2'($urandom);
            addr = 64'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << size) - 64'd1);
            do_req($sformatf("rnd%0d", t), 1'($urandom), size, 1'($urandom), addr,
                   {$urandom, $urandom}, $urandom_range(0, 2), got);
        end

        // Final memory image against the reference model
        for (int i = 0; i < 32; i++) check($sformatf("mem[%0d]", i), phys_mem[i], model_dword(i));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
